// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: general registers R2/R4/R5, PC, IR, MAR, MDR,
// HI/LO, Y, 64-bit Z and a combinational ALU (A = Y, B = bus).
// Optional feature macro: DATAPATH_MULDIV_EN enables the signed multiplier and
// divider; without it MUL/DIV keep their priority slot but produce Z = 0.
module datapath #(
   parameter int unsigned WIDTH = 32
) (
   output logic [WIDTH-1:0] outp,
   input  logic             PCout,
   input  logic             Zhiout,
   input  logic             Zlowout,
   input  logic             MDRout,
   input  logic             R2out,
   input  logic             HIout,
   input  logic             LOout,
   input  logic             R5out,
   input  logic             MARin,
   input  logic             Zin,
   input  logic             PCin,
   input  logic             MDRin,
   input  logic             IRin,
   input  logic             Yin,
   input  logic             HIin,
   input  logic             LOin,
   input  logic             IncPC,
   input  logic             Read,
   input  logic             R5in,
   input  logic             R2in,
   input  logic             R4in,
   input  logic             Clock,
   input  logic             Clear,
   input  logic [WIDTH-1:0] Mdatain,
   input  logic             AND,
   input  logic             OR,
   input  logic             ADD,
   input  logic             SUB,
   input  logic             MUL,
   input  logic             DIV,
   input  logic             SHR,
   input  logic             SHL,
   input  logic             ROR,
   input  logic             ROL,
   input  logic             NEG,
   input  logic             NOT
);

   localparam int unsigned ZW  = 2 * WIDTH;
   localparam int unsigned SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] r2_q, r4_q, r5_q, pc_q, ir_q, mar_q, mdr_q, hi_q, lo_q, y_q;
   logic [ZW-1:0]    z_q;
   logic [WIDTH-1:0] mdr_d;
   logic [ZW-1:0]    z_d;
   logic [WIDTH-1:0] bus;

   logic [WIDTH-1:0] alu_a, alu_b;
   logic [SHW-1:0]   sh_amt;
   logic [ZW-1:0]    dbl, ror_full, rol_full;

   // IR, MAR and R4 have no consumer inside this block
   logic unused_regs;
   assign unused_regs = ^{ir_q, mar_q, r4_q};

   // Bus source mux, fixed priority, idle bus reads as zero
   always_comb begin
      bus = '0;
      if (PCout)        bus = pc_q;
      else if (Zhiout)  bus = z_q[ZW-1:WIDTH];
      else if (Zlowout) bus = z_q[WIDTH-1:0];
      else if (MDRout)  bus = mdr_q;
      else if (R2out)   bus = r2_q;
      else if (R5out)   bus = r5_q;
      else if (HIout)   bus = hi_q;
      else if (LOout)   bus = lo_q;
   end

   assign outp  = bus;
   assign alu_a = y_q;
   assign alu_b = bus;
   assign mdr_d = Read ? Mdatain : bus;

   // Shift/rotate helpers: rotations taken from a doubled copy of A
   always_comb begin
      sh_amt   = alu_b[SHW-1:0];
      dbl      = {alu_a, alu_a};
      ror_full = dbl >> sh_amt;
      rol_full = dbl << sh_amt;
   end

`ifdef DATAPATH_MULDIV_EN
   logic signed [ZW-1:0]    a_ext, b_ext, prod;
   logic signed [WIDTH-1:0] a_s, b_safe, quot, rem;
   logic                    div_by_zero;

   // Signed multiply and divide; a zero divisor is replaced to keep the divider defined
   always_comb begin
      a_ext       = {{WIDTH{alu_a[WIDTH-1]}}, alu_a};
      b_ext       = {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
      prod        = a_ext * b_ext;
      div_by_zero = (alu_b == '0);
      a_s         = alu_a;
      b_safe      = div_by_zero ? WIDTH'(1) : alu_b;
      quot        = a_s / b_safe;
      rem         = a_s % b_safe;
   end
`endif

   // ALU result: first selected op in port order wins, then IncPC, else pass B
   always_comb begin
      z_d = {{WIDTH{1'b0}}, alu_b};
      if (AND)      z_d = {{WIDTH{1'b0}}, alu_a & alu_b};
      else if (OR)  z_d = {{WIDTH{1'b0}}, alu_a | alu_b};
      else if (ADD) z_d = {{WIDTH{1'b0}}, alu_a + alu_b};
      else if (SUB) z_d = {{WIDTH{1'b0}}, alu_a - alu_b};
`ifdef DATAPATH_MULDIV_EN
      else if (MUL) z_d = prod;
      else if (DIV) z_d = div_by_zero ? {alu_a, {WIDTH{1'b1}}} : {rem, quot};
`else
      else if (MUL || DIV) z_d = '0;
`endif
      else if (SHR)   z_d = {{WIDTH{1'b0}}, alu_a >> sh_amt};
      else if (SHL)   z_d = {{WIDTH{1'b0}}, alu_a << sh_amt};
      else if (ROR)   z_d = {{WIDTH{1'b0}}, ror_full[WIDTH-1:0]};
      else if (ROL)   z_d = {{WIDTH{1'b0}}, rol_full[ZW-1:WIDTH]};
      else if (NEG)   z_d = {{WIDTH{1'b0}}, WIDTH'(0) - alu_b};
      else if (NOT)   z_d = {{WIDTH{1'b0}}, ~alu_b};
      else if (IncPC) z_d = {{WIDTH{1'b0}}, alu_b + WIDTH'(1)};
   end

   // Register file loads from the bus; Clear wins over any load
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         r2_q  <= '0;
         r4_q  <= '0;
         r5_q  <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         y_q   <= '0;
         z_q   <= '0;
      end else begin
         if (R2in)  r2_q  <= bus;
         if (R4in)  r4_q  <= bus;
         if (R5in)  r5_q  <= bus;
         if (PCin)  pc_q  <= bus;
         if (IRin)  ir_q  <= bus;
         if (MARin) mar_q <= bus;
         if (MDRin) mdr_q <= mdr_d;
         if (HIin)  hi_q  <= bus;
         if (LOin)  lo_q  <= bus;
         if (Yin)   y_q   <= bus;
         if (Zin)   z_q   <= z_d;
      end
   end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the single-bus datapath.
module tb_datapath;

   logic [31:0] outp;
   logic PCout, Zhiout, Zlowout, MDRout, R2out, HIout, LOout, R5out;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
   logic IncPC, Read, R5in, R2in, R4in;
   logic Clock = 1'b0;
   logic Clear = 1'b0;
   logic [31:0] Mdatain;
   logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT;

   int n_tests = 0;
   int n_fail  = 0;

   datapath dut (
      .outp(outp), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
      .R2out(R2out), .HIout(HIout), .LOout(LOout), .R5out(R5out), .MARin(MARin),
      .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
      .LOin(LOin), .IncPC(IncPC), .Read(Read), .R5in(R5in), .R2in(R2in), .R4in(R4in),
      .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain), .AND(AND), .OR(OR), .ADD(ADD),
      .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
      .NEG(NEG), .NOT(NOT)
   );

   always #5 Clock = ~Clock;

`ifdef DATAPATH_MULDIV_EN
   localparam bit MULDIV = 1'b1;
`else
   localparam bit MULDIV = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr_ctl();
      {PCout, Zhiout, Zlowout, MDRout, R2out, HIout, LOout, R5out} = '0;
      {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin} = '0;
      {IncPC, Read, R5in, R2in, R4in} = '0;
      {AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT} = '0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic load_mdr(input logic [31:0] v);
      clr_ctl();
      Mdatain = v; Read = 1'b1; MDRin = 1'b1;
      tick();
      clr_ctl();
   endtask

   task automatic load_y(input logic [31:0] v);
      load_mdr(v);
      MDRout = 1'b1; Yin = 1'b1;
      tick();
      clr_ctl();
   endtask

   task automatic set_op(input int op);
      case (op)
         0:  AND = 1'b1;
         1:  OR  = 1'b1;
         2:  ADD = 1'b1;
         3:  SUB = 1'b1;
         4:  MUL = 1'b1;
         5:  DIV = 1'b1;
         6:  SHR = 1'b1;
         7:  SHL = 1'b1;
         8:  ROR = 1'b1;
         9:  ROL = 1'b1;
         10: NEG = 1'b1;
         11: NOT = 1'b1;
         12: IncPC = 1'b1;
         default: ;
      endcase
   endtask

   // Y <- y, bus <- b through MDR, then one ALU cycle into Z
   task automatic run_op(input string tag, input logic [31:0] y, input logic [31:0] b,
                         input int op, input logic [63:0] exp);
      load_y(y);
      load_mdr(b);
      MDRout = 1'b1; Zin = 1'b1;
      set_op(op);
      tick();
      clr_ctl();
      check(tag, dut.z_q, exp);
   endtask

   initial begin
      clr_ctl();
      Mdatain = '0;

      // Reset
      #2 Clear = 1'b1;
      PCout = 1'b1;
      #1 check("reset_pc", dut.pc_q, 64'h0);
      check("reset_z", dut.z_q, 64'h0);
      check("reset_outp", outp, 64'h0);
      #1 Clear = 1'b0;
      clr_ctl();

      // Memory read into MDR, then MDR -> R2
      load_mdr(32'd12);
      check("mdr_load", dut.mdr_q, 64'd12);
      MDRout = 1'b1; R2in = 1'b1;
      #1 check("bus_mdr", outp, 64'd12);
      tick();
      clr_ctl();
      check("r2_move", dut.r2_q, 64'd12);

      // Fetch sequence
      PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      tick();
      clr_ctl();
      check("fetch_mar", dut.mar_q, 64'h0);
      check("fetch_z", dut.z_q, 64'h1);
      Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h1A92_0000;
      #1 check("bus_zlow", outp, 64'h1);
      tick();
      clr_ctl();
      check("fetch_pc", dut.pc_q, 64'h1);
      check("fetch_mdr", dut.mdr_q, 64'h1A92_0000);
      MDRout = 1'b1; IRin = 1'b1;
      tick();
      clr_ctl();
      check("fetch_ir", dut.ir_q, 64'h1A92_0000);

      // NOT R2 -> Z -> R5
      R2out = 1'b1; NOT = 1'b1; Zin = 1'b1;
      tick();
      clr_ctl();
      check("not_r2", dut.z_q, 64'h0000_0000_FFFF_FFF3);
      Zlowout = 1'b1; R5in = 1'b1;
      tick();
      clr_ctl();
      R5out = 1'b1;
      #1 check("r5_out", outp, 64'hFFFF_FFF3);
      clr_ctl();

      // Multiply / divide
      run_op("mul_neg", 32'hFFFF_FFFA, 32'd4, 4, MULDIV ? 64'hFFFF_FFFF_FFFF_FFE8 : 64'h0);
      Zhiout = 1'b1;
      #1 check("mul_zhi_bus", outp, MULDIV ? 64'hFFFF_FFFF : 64'h0);
      clr_ctl();
      run_op("div_neg", 32'hFFFF_FFF9, 32'd2, 5, MULDIV ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0);
      run_op("div_zero", 32'hFFFF_FFF9, 32'd0, 5, MULDIV ? 64'hFFFF_FFF9_FFFF_FFFF : 64'h0);
      Zhiout = 1'b1; Zlowout = 1'b1;
      #1 check("prio_zhi_zlo", outp, MULDIV ? 64'hFFFF_FFF9 : 64'h0);
      clr_ctl();
      Zlowout = 1'b1; MDRout = 1'b1;
      #1 check("prio_zlo_mdr", outp, MULDIV ? 64'hFFFF_FFFF : 64'h0);
      clr_ctl();

      // Shifts, rotates and 32-bit arithmetic
      run_op("ror1", 32'h8000_0001, 32'd1, 8, 64'hC000_0000);
      run_op("shr1", 32'h8000_0001, 32'd1, 6, 64'h4000_0000);
      run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 2, 64'h0);
      run_op("sub", 32'd5, 32'd7, 3, 64'hFFFF_FFFE);
      run_op("and", 32'hF0F0_FF00, 32'h0FF0_F0F0, 0, 64'h00F0_F000);
      run_op("or", 32'hF0F0_0000, 32'h000F_000F, 1, 64'hF0FF_000F);
      run_op("shl31", 32'd1, 32'd31, 7, 64'h8000_0000);
      run_op("rol4", 32'h8000_0001, 32'd4, 9, 64'h0000_0018);
      run_op("ror_amt0", 32'h1234_5678, 32'd32, 8, 64'h1234_5678);
      run_op("neg", 32'd123, 32'd5, 10, 64'hFFFF_FFFB);
      run_op("incpc", 32'd9, 32'h7FFF_FFFF, 12, 64'h8000_0000);
      run_op("no_op", 32'd1, 32'h0000_ABCD, 13, 64'h0000_ABCD);

      // Op priority
      load_y(32'd3);
      load_mdr(32'd5);
      MDRout = 1'b1; Zin = 1'b1; ADD = 1'b1; SUB = 1'b1;
      tick();
      clr_ctl();
      check("prio_add_sub", dut.z_q, 64'd8);
      MDRout = 1'b1; Zin = 1'b1; OR = 1'b1; IncPC = 1'b1;
      tick();
      clr_ctl();
      check("prio_or_inc", dut.z_q, 64'd7);
      load_y(32'd2);
      load_mdr(32'd3);
      MDRout = 1'b1; Zin = 1'b1; MUL = 1'b1; SHR = 1'b1;
      tick();
      clr_ctl();
      check("prio_mul_shr", dut.z_q, MULDIV ? 64'd6 : 64'd0);

      // Bus priority and HI/LO/R4
      load_mdr(32'h5A5A);
      PCout = 1'b1; MDRout = 1'b1;
      #1 check("prio_pc_mdr", outp, 64'h1);
      PCout = 1'b0; R2out = 1'b1;
      #1 check("prio_mdr_r2", outp, 64'h5A5A);
      clr_ctl();
      load_mdr(32'd77);
      MDRout = 1'b1; HIin = 1'b1;
      tick();
      load_mdr(32'd88);
      MDRout = 1'b1; LOin = 1'b1; R4in = 1'b1;
      tick();
      clr_ctl();
      check("r4_load", dut.r4_q, 64'd88);
      LOout = 1'b1;
      #1 check("lo_out", outp, 64'd88);
      HIout = 1'b1;
      #1 check("prio_hi_lo", outp, 64'd77);
      R5out = 1'b1;
      #1 check("prio_r5_hi", outp, 64'hFFFF_FFF3);
      clr_ctl();

      // Clear mid-cycle, then Clear held across an edge with loads asserted
      MDRout = 1'b1;
      #2 Clear = 1'b1;
      #1 check("clr_async_mdr", dut.mdr_q, 64'h0);
      check("clr_async_pc", dut.pc_q, 64'h0);
      check("clr_async_r5", dut.r5_q, 64'h0);
      check("clr_async_outp", outp, 64'h0);
      R2in = 1'b1; Zin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'd55; IncPC = 1'b1;
      tick();
      check("clr_over_mdr", dut.mdr_q, 64'h0);
      check("clr_over_z", dut.z_q, 64'h0);
      Clear = 1'b0;
      clr_ctl();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
